// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Rebuilds parallel words from an MSB-first serial stream. The stream comes
// from the companion PISO serializer. A framing strobe (sync) marks the MSB of
// each word. Completed words are presented on a valid/ready output register.
// The block reports overrun (sticky) and framing errors (one-cycle pulse).
//
// Ports:
//   clk        in   rising-edge clock, shared with the serializer
//   rst        in   asynchronous active-high reset
//   en         in   bit strobe; d_in and sync are sampled only when en=1
//   sync       in   marks the cycle whose d_in is the MSB of a new word
//   d_in       in   serial data, MSB first
//   q          out  last completed word (WIDTH bits)
//   valid      out  q holds an unconsumed word
//   ready      in   consumer takes q on a valid&&ready edge
//   busy       out  a word is partially assembled
//   overrun    out  sticky: a word completed while q was still unconsumed
//   frame_err  out  one-cycle pulse: sync arrived mid-word
//   clr_err    in   synchronous clear of overrun
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             d_in,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             complete_s;

  // Next-state logic for the bit assembler: shift, count, detect completion/resync.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    complete_s  = 1'b0;
    frame_err_d = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            sr_d    = {{(WIDTH-1){1'b0}}, d_in};
            cnt_d   = CNT_ONE;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (sync) begin
            // Resync: sync always marks a new MSB, so it beats completion.
            sr_d        = {{(WIDTH-1){1'b0}}, d_in};
            cnt_d       = CNT_ONE;
            frame_err_d = 1'b1;
          end else begin
            sr_d = {sr_q[WIDTH-2:0], d_in};
            if (cnt_q == CNT_LAST) begin
              complete_s = 1'b1;
              cnt_d      = {CNT_W{1'b0}};
              state_d    = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == SHIFT);
  end

  // Next-state logic for the output register, handshake and overrun flag.
  always_comb begin
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete_s && (!valid_q || ready)) begin
      q_d     = sr_d;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // A new overrun takes precedence over a clear on the same edge.
    if (complete_s && valid_q && !ready) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // FSM and output registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      sr_q        <= {WIDTH{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign q         = q_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Directed testbench for sipo_deserializer (WIDTH=4). Inputs are driven at the
// falling edge and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync;
  logic       d_in;
  logic [3:0] q;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       overrun;
  logic       frame_err;
  logic       clr_err;

  int n_checks;
  int n_fail;

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .d_in      (d_in),
    .q         (q),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled bit, sampled on the next rising edge.
  task automatic send_bit(input logic s, input logic b);
    @(negedge clk);
    en   = 1'b1;
    sync = s;
    d_in = b;
    @(posedge clk);
    #1;
  endtask

  // One disabled cycle; sync/d_in are driven high to show they are ignored.
  task automatic idle_cycle();
    @(negedge clk);
    en   = 1'b0;
    sync = 1'b1;
    d_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_bit(i == 3, w[i]);
    end
  endtask

  // Consume whatever is in q and clear overrun.
  task automatic drain();
    @(negedge clk);
    en      = 1'b0;
    ready   = 1'b1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    ready   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    sync     = 1'b0;
    d_in     = 1'b0;
    ready    = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_q",         32'(q),         32'h0);
    check_eq("rst_valid",     32'(valid),     32'h0);
    check_eq("rst_busy",      32'(busy),      32'h0);
    check_eq("rst_overrun",   32'(overrun),   32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single word 1101; busy for 3 cycles, valid on the 4th edge.
    send_bit(1'b1, 1'b1);
    check_eq("w1_busy_b1",  32'(busy),  32'h1);
    check_eq("w1_valid_b1", 32'(valid), 32'h0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check_eq("w1_busy_b3",  32'(busy),  32'h1);
    check_eq("w1_valid_b3", 32'(valid), 32'h0);
    send_bit(1'b0, 1'b1);
    check_eq("w1_valid", 32'(valid), 32'h1);
    check_eq("w1_q",     32'(q),     32'hD);
    check_eq("w1_busy",  32'(busy),  32'h0);
    @(negedge clk);
    en    = 1'b0;
    ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("w1_consumed", 32'(valid), 32'h0);
    check_eq("w1_q_hold",   32'(q),     32'hD);

    // Back-to-back 3 then A with ready held high.
    send_word(4'h3);
    check_eq("b2b_valid1", 32'(valid), 32'h1);
    check_eq("b2b_q1",     32'(q),     32'h3);
    send_bit(1'b1, 1'b1);
    check_eq("b2b_consume", 32'(valid), 32'h0);
    check_eq("b2b_busy",    32'(busy),  32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check_eq("b2b_valid2",  32'(valid),   32'h1);
    check_eq("b2b_q2",      32'(q),       32'hA);
    check_eq("b2b_overrun", 32'(overrun), 32'h0);
    drain();

    // Overrun: 5 then 9 with ready low.
    send_word(4'h5);
    check_eq("ovr_q1",   32'(q),       32'h5);
    check_eq("ovr_ovr1", 32'(overrun), 32'h0);
    send_word(4'h9);
    check_eq("ovr_q2",     32'(q),       32'h5);
    check_eq("ovr_ovr2",   32'(overrun), 32'h1);
    check_eq("ovr_valid2", 32'(valid),   32'h1);
    @(negedge clk);
    en      = 1'b0;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check_eq("clr_ovr",   32'(overrun), 32'h0);
    check_eq("clr_valid", 32'(valid),   32'h1);
    check_eq("clr_q",     32'(q),       32'h5);
    // Completion with valid&&ready on the same edge loads the new word.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    ready = 1'b1;
    send_bit(1'b0, 1'b0);
    ready = 1'b0;
    check_eq("swap_q",     32'(q),       32'h6);
    check_eq("swap_valid", 32'(valid),   32'h1);
    check_eq("swap_ovr",   32'(overrun), 32'h0);
    // Overrun set and clr_err on the same edge: set wins.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    clr_err = 1'b1;
    send_bit(1'b0, 1'b1);
    clr_err = 1'b0;
    check_eq("setwins_ovr", 32'(overrun), 32'h1);
    check_eq("setwins_q",   32'(q),       32'h6);
    drain();
    check_eq("drain_valid", 32'(valid),   32'h0);
    check_eq("drain_ovr",   32'(overrun), 32'h0);

    // Resync: partial 1,0 discarded, new word 0110.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check_eq("rs_fe_before", 32'(frame_err), 32'h0);
    send_bit(1'b1, 1'b0);
    check_eq("rs_fe_pulse", 32'(frame_err), 32'h1);
    check_eq("rs_busy",     32'(busy),      32'h1);
    idle_cycle();
    check_eq("rs_fe_drop",   32'(frame_err), 32'h0);
    check_eq("rs_busy_idle", 32'(busy),      32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check_eq("rs_valid_early", 32'(valid), 32'h0);
    send_bit(1'b0, 1'b0);
    check_eq("rs_q",     32'(q),         32'h6);
    check_eq("rs_valid", 32'(valid),     32'h1);
    check_eq("rs_fe_end", 32'(frame_err), 32'h0);
    drain();

    // en gating: 1,0,1,1 with two disabled cycles between bits.
    send_bit(1'b1, 1'b1);
    idle_cycle();
    idle_cycle();
    send_bit(1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    send_bit(1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    check_eq("en_valid_early", 32'(valid),     32'h0);
    check_eq("en_busy",        32'(busy),      32'h1);
    check_eq("en_fe",          32'(frame_err), 32'h0);
    send_bit(1'b0, 1'b1);
    check_eq("en_valid", 32'(valid), 32'h1);
    check_eq("en_q",     32'(q),     32'hB);

    // Async reset mid-word (q still holds B, valid high).
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_q",     32'(q),     32'h0);
    check_eq("arst_valid", 32'(valid), 32'h0);
    check_eq("arst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    send_word(4'hC);
    check_eq("post_rst_q",     32'(q),     32'hC);
    check_eq("post_rst_valid", 32'(valid), 32'h1);
    check_eq("post_rst_fe",    32'(frame_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
